// File: rtl/hpdcache_mem_refill_serializer_pkg.sv
// Shared types, default widths and helpers for the refill serializer.
package hpdcache_mem_refill_pkg;

  localparam int unsigned HPDCACHE_CL_WIDTH       = 512;
  localparam int unsigned HPDCACHE_MEM_DATA_WIDTH = 64;
  localparam int unsigned HPDCACHE_MEM_ID_WIDTH   = 4;
  localparam int unsigned HPDCACHE_REFILL_FIFO_DEPTH = 2;

  // One buffered refill line at the default widths.
  typedef struct packed {
    logic [HPDCACHE_MEM_ID_WIDTH-1:0] id;
    logic                             error;
    logic [HPDCACHE_CL_WIDTH-1:0]     data;
  } line_entry_t;

  typedef enum logic {
    IDLE,
    SEND
  } refill_ser_state_e;

  function automatic int unsigned beats_of(input int unsigned cl_w, input int unsigned mem_w);
    return cl_w / mem_w;
  endfunction

endpackage

// File: rtl/hpdcache_mem_refill_serializer_if.sv
// Line-in / beat-out handshake bundle of the refill serializer.
interface hpdcache_mem_refill_serializer_if
  import hpdcache_mem_refill_pkg::*;
#(
  parameter int unsigned CL_WIDTH       = HPDCACHE_CL_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH = HPDCACHE_MEM_DATA_WIDTH,
  parameter int unsigned MEM_ID_WIDTH   = HPDCACHE_MEM_ID_WIDTH
);
  logic                      line_valid_i;
  logic                      line_ready_o;
  logic [MEM_ID_WIDTH-1:0]   line_id_i;
  logic [CL_WIDTH-1:0]       line_data_i;
  logic                      line_error_i;

  logic                      beat_valid_o;
  logic                      beat_ready_i;
  logic [MEM_ID_WIDTH-1:0]   beat_id_o;
  logic [MEM_DATA_WIDTH-1:0] beat_data_o;
  logic                      beat_error_o;
  logic                      beat_last_o;

  // Serializer side.
  modport slave (
    input  line_valid_i, line_id_i, line_data_i, line_error_i, beat_ready_i,
    output line_ready_o, beat_valid_o, beat_id_o, beat_data_o, beat_error_o, beat_last_o
  );

  // Memory model / cache side.
  modport master (
    output line_valid_i, line_id_i, line_data_i, line_error_i, beat_ready_i,
    input  line_ready_o, beat_valid_o, beat_id_o, beat_data_o, beat_error_o, beat_last_o
  );
endinterface

// File: rtl/hpdcache_mem_refill_line_fifo.sv
// Generic depth-N valid/ready FIFO with registered occupancy.
module hpdcache_mem_refill_line_fifo
  import hpdcache_mem_refill_pkg::*;
#(
  parameter int unsigned DEPTH = HPDCACHE_REFILL_FIFO_DEPTH,
  parameter type entry_t = line_entry_t,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  entry_t           push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output entry_t           pop_data_o,
  output logic [OCC_W-1:0] occupancy_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               push_fire, pop_fire;

  // Readiness depends on stored occupancy only, so a same-cycle pop never frees a slot.
  assign push_ready_o = (occ_q < OCC_W'(DEPTH));
  assign pop_valid_o  = (occ_q != '0);
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign occupancy_o  = occ_q;
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = pop_valid_o & pop_ready_i;

  // Pointer advance with wrap and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_fire) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_fire && !pop_fire) begin
      occ_d = occ_q + 1'b1;
    end else if (pop_fire && !push_fire) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage; contents are only observed while occupancy says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end
endmodule

// File: rtl/hpdcache_mem_refill_serializer.sv
// Buffers whole refill lines and emits each as BEATS memory-width beats, LSB slice first.
module hpdcache_mem_refill_serializer
  import hpdcache_mem_refill_pkg::*;
#(
  parameter int unsigned CL_WIDTH        = HPDCACHE_CL_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH  = HPDCACHE_MEM_DATA_WIDTH,
  parameter int unsigned MEM_ID_WIDTH    = HPDCACHE_MEM_ID_WIDTH,
  parameter int unsigned LINE_FIFO_DEPTH = HPDCACHE_REFILL_FIFO_DEPTH,
  localparam int unsigned OCC_W = $clog2(LINE_FIFO_DEPTH + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  hpdcache_mem_refill_serializer_if.slave   io,
  output logic [OCC_W-1:0]                  occupancy_o,
  output logic                              busy_o
);
  localparam int unsigned BEATS      = beats_of(CL_WIDTH, MEM_DATA_WIDTH);
  localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [MEM_ID_WIDTH-1:0] id;
    logic                    error;
    logic [CL_WIDTH-1:0]     data;
  } entry_t;

  entry_t                                push_entry, head;
  logic                                  fifo_push_ready, fifo_pop_valid, fifo_pop;
  logic [OCC_W-1:0]                      occ;
  logic                                  push_fire, last_beat;
  logic [BEATS-1:0][MEM_DATA_WIDTH-1:0]  head_beats;
  refill_ser_state_e                     state_q, state_d;
  logic [BEAT_CNT_W-1:0]                 cnt_q, cnt_d;

  if (CL_WIDTH % MEM_DATA_WIDTH != 0) begin : g_bad_width
    $error("CL_WIDTH must be a multiple of MEM_DATA_WIDTH");
  end

  assign push_entry      = '{id: io.line_id_i, error: io.line_error_i, data: io.line_data_i};
  assign io.line_ready_o = fifo_push_ready;
  assign push_fire       = io.line_valid_i & fifo_push_ready;
  assign head_beats      = head.data;
  assign last_beat       = (cnt_q == BEAT_CNT_W'(BEATS - 1));
  assign occupancy_o     = occ;
  assign busy_o          = (occ != '0);

  hpdcache_mem_refill_line_fifo #(
    .DEPTH   (LINE_FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_line_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_valid_i (io.line_valid_i),
    .push_ready_o (fifo_push_ready),
    .push_data_i  (push_entry),
    .pop_valid_o  (fifo_pop_valid),
    .pop_ready_i  (fifo_pop),
    .pop_data_o   (head),
    .occupancy_o  (occ)
  );

  // Next-state, beat counter and beat outputs; beat_* are zero outside SEND.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fifo_pop        = 1'b0;
    io.beat_valid_o = 1'b0;
    io.beat_id_o    = '0;
    io.beat_data_o  = '0;
    io.beat_error_o = 1'b0;
    io.beat_last_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_pop_valid) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        io.beat_valid_o = 1'b1;
        io.beat_id_o    = head.id;
        io.beat_error_o = head.error;
        io.beat_data_o  = head_beats[cnt_q];
        io.beat_last_o  = last_beat;
        if (io.beat_ready_i) begin
          if (last_beat) begin
            fifo_pop = 1'b1;
            cnt_d    = '0;
            // Stay in SEND when a line survives the pop, including one pushed this cycle.
            if (!((occ > OCC_W'(1)) || push_fire)) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and beat counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  a_line_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (io.line_valid_i && !io.line_ready_o) |=>
      (io.line_valid_i && $stable(io.line_id_i) && $stable(io.line_error_i) && $stable(io.line_data_i)));

  a_ready_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown(io.beat_ready_i));
endmodule

// File: tb/tb_hpdcache_mem_refill_serializer.sv
// Scoreboard bench: stimulus queues expected beats, monitors pop and compare on each handshake.
module tb_hpdcache_mem_refill_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpdcache_mem_refill_serializer_if #(.CL_WIDTH(512), .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(4)) bus ();
  hpdcache_mem_refill_serializer_if #(.CL_WIDTH(64),  .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(4)) bus1 ();

  logic [1:0] occ, occ1;
  logic       busy, busy1;

  hpdcache_mem_refill_serializer #(
    .CL_WIDTH(512), .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(4), .LINE_FIFO_DEPTH(2)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .io(bus), .occupancy_o(occ), .busy_o(busy)
  );

  hpdcache_mem_refill_serializer #(
    .CL_WIDTH(64), .MEM_DATA_WIDTH(64), .MEM_ID_WIDTH(4), .LINE_FIFO_DEPTH(2)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .io(bus1), .occupancy_o(occ1), .busy_o(busy1)
  );

  typedef struct {
    logic [3:0]  id;
    logic        err;
    logic        last;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp1_q[$];

  int unsigned checks = 0, passed = 0;
  int unsigned cyc = 0, hs_cnt = 0, last1_cyc = 0, acc_cyc = 0;
  int unsigned b1_first = 0, b1_last = 0, b1_cnt = 0;
  int unsigned ready_mode = 0, ph = 0;
  logic        stalled = 1'b0, bubble_chk = 1'b0;
  logic [69:0] prev_beat = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Word k of line id: 0xC0DE00_0<id>_000000_<k>
  function automatic logic [63:0] word(input logic [3:0] id, input int unsigned k);
    return {24'hC0DE00, 4'h0, id, 24'h0, k[7:0]};
  endfunction

  always @(posedge clk) cyc++;

  // Cache back-pressure: 0 = always ready, 1 = 1,0,0 pattern, 2 = never ready.
  initial begin
    bus.beat_ready_i  = 1'b1;
    bus1.beat_ready_i = 1'b1;
  end
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.beat_ready_i = 1'b1;
      1: begin bus.beat_ready_i = (ph == 0); ph = (ph + 1) % 3; end
      default: bus.beat_ready_i = 1'b0;
    endcase
  end

  // Monitor for the 8-beat DUT.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled    = 1'b0;
      bubble_chk = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", bus.beat_valid_o, 1'b1);
        check("stall_hold", {bus.beat_id_o, bus.beat_error_o, bus.beat_last_o, bus.beat_data_o}, prev_beat);
      end
      if (bubble_chk) check("no_bubble", bus.beat_valid_o, 1'b1);
      bubble_chk = 1'b0;
      if (bus.beat_valid_o && bus.beat_ready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {bus.beat_id_o, bus.beat_error_o, bus.beat_last_o, bus.beat_data_o},
                {e.id, e.err, e.last, e.data});
          if (e.last && e.id == 4'd1) last1_cyc = cyc;
          if (e.last && exp_q.size() != 0 && ready_mode == 0) bubble_chk = 1'b1;
        end
      end
      stalled   = bus.beat_valid_o && !bus.beat_ready_i;
      prev_beat = {bus.beat_id_o, bus.beat_error_o, bus.beat_last_o, bus.beat_data_o};
    end
  end

  // Monitor for the single-beat DUT.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus1.beat_valid_o && bus1.beat_ready_i) begin
      if (b1_cnt == 0) b1_first = cyc;
      b1_last = cyc;
      b1_cnt++;
      if (exp1_q.size() == 0) begin
        check("unexpected_beat1", 1'b1, 1'b0);
      end else begin
        e = exp1_q.pop_front();
        check("beat1", {bus1.beat_id_o, bus1.beat_error_o, bus1.beat_last_o, bus1.beat_data_o},
              {e.id, e.err, e.last, e.data});
      end
    end
  end

  task automatic send_line(input logic [3:0] id, input logic err);
    logic [511:0] l;
    int unsigned  n = 0;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = word(id, k);
    @(posedge clk); #1;
    bus.line_valid_i = 1'b1;
    bus.line_id_i    = id;
    bus.line_error_i = err;
    bus.line_data_i  = l;
    @(negedge clk);
    while (!bus.line_ready_o && n < 200) begin @(negedge clk); n++; end
    if (!bus.line_ready_o) begin
      check("accept_timeout", 1'b0, 1'b1);
    end else begin
      for (int k = 0; k < 8; k++) exp_q.push_back('{id: id, err: err, last: (k == 7), data: word(id, k)});
      acc_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    bus.line_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 400) begin @(negedge clk); n++; end
    check("drain", (exp_q.size() == 0 && !busy), 1'b1);
  endtask

  initial begin
    int unsigned base, n;
    bus.line_valid_i  = 1'b0; bus.line_id_i  = '0; bus.line_error_i  = 1'b0; bus.line_data_i  = '0;
    bus1.line_valid_i = 1'b0; bus1.line_id_i = '0; bus1.line_error_i = 1'b0; bus1.line_data_i = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_beat_valid", bus.beat_valid_o, 1'b0);
    check("rst_line_ready", bus.line_ready_o, 1'b1);
    check("rst_occ", occ, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_outputs", {bus.beat_id_o, bus.beat_error_o, bus.beat_last_o, bus.beat_data_o}, 70'd0);
    check("rst_line_ready1", bus1.line_ready_o, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single line, always ready
    base = hs_cnt;
    send_line(4'd3, 1'b0);
    @(negedge clk);
    check("occ_after_push", occ, 2'd1);
    check("busy_after_push", busy, 1'b1);
    n = 0;
    while (!bus.beat_valid_o && n < 20) begin @(negedge clk); n++; end
    check("first_beat_latency", cyc - acc_cyc, 1);
    wait_drain();
    check("occ_after_drain", occ, 2'd0);
    check("single_hs_count", hs_cnt - base, 8);

    // Back-pressure 1,0,0
    ready_mode = 1; ph = 0;
    base = hs_cnt;
    send_line(4'd4, 1'b0);
    wait_drain();
    check("bp_hs_count", hs_cnt - base, 8);
    ready_mode = 0;

    // Fill with the cache stalled
    ready_mode = 2;
    base = hs_cnt;
    send_line(4'd1, 1'b0);
    send_line(4'd2, 1'b0);
    repeat (2) @(negedge clk);
    check("full_occ", occ, 2'd2);
    check("full_line_ready", bus.line_ready_o, 1'b0);
    ready_mode = 0;
    send_line(4'd3, 1'b0);
    check("refill_accept_after_pop", acc_cyc, last1_cyc + 2);
    wait_drain();
    check("fill_hs_count", hs_cnt - base, 24);

    // Error line then clean line
    send_line(4'd5, 1'b1);
    send_line(4'd6, 1'b0);
    wait_drain();

    // Reset mid-line with a second line queued
    base = hs_cnt;
    send_line(4'd7, 1'b0);
    send_line(4'd9, 1'b0);
    n = 0;
    while (hs_cnt - base < 4 && n < 100) begin @(negedge clk); #1; n++; end
    check("reach_beat3", hs_cnt - base, 4);
    rst = 1'b1;
    #1;
    check("midrst_beat_valid", bus.beat_valid_o, 1'b0);
    check("midrst_outputs", {bus.beat_id_o, bus.beat_error_o, bus.beat_last_o, bus.beat_data_o}, 70'd0);
    check("midrst_occ", occ, 2'd0);
    check("midrst_line_ready", bus.line_ready_o, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = hs_cnt;
    repeat (10) @(negedge clk);
    check("post_rst_no_beats", hs_cnt - base, 0);
    check("post_rst_line_ready", bus.line_ready_o, 1'b1);
    check("post_rst_occ", occ, 2'd0);
    send_line(4'd8, 1'b0);
    wait_drain();
    check("post_rst_hs_count", hs_cnt - base, 8);

    // Single-beat configuration, four back-to-back lines
    @(posedge clk); #1;
    bus1.line_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.line_id_i    = 4'(10 + i);
      bus1.line_error_i = 1'b0;
      bus1.line_data_i  = word(4'(10 + i), 0);
      n = 0;
      @(negedge clk);
      while (!bus1.line_ready_o && n < 50) begin @(negedge clk); n++; end
      if (!bus1.line_ready_o) check("accept_timeout1", 1'b0, 1'b1);
      else exp1_q.push_back('{id: 4'(10 + i), err: 1'b0, last: 1'b1, data: word(4'(10 + i), 0)});
      @(posedge clk); #1;
    end
    bus1.line_valid_i = 1'b0;
    n = 0;
    while ((exp1_q.size() != 0 || busy1) && n < 100) begin @(negedge clk); n++; end
    check("drain1", (exp1_q.size() == 0 && !busy1), 1'b1);
    check("b1_count", b1_cnt, 4);
    check("b1_throughput", b1_last - b1_first, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hpdcache_mem_refill_serializer.md
Name: hpdcache_mem_refill_serializer

Overview:
Memory-side refill response stage for the HPDcache verification environment. Accepts whole cache-line read responses from the memory response model and serializes each into HPDCACHE_MEM_DATA_WIDTH beats on the cache's memory read-response channel. Lines are buffered in a small FIFO so the model can run ahead of cache back-pressure.

Parameters:
CL_WIDTH, 512, cache-line width in bits (PARAM_CL_WORDS*PARAM_WORD_WIDTH); must be a multiple of MEM_DATA_WIDTH.
MEM_DATA_WIDTH, 64, beat width (HPDCACHE_MEM_DATA_WIDTH).
MEM_ID_WIDTH, 4, transaction ID width (HPDCACHE_MEM_ID_WIDTH).
LINE_FIFO_DEPTH, 2, buffered lines; must be >= 1.
Derived: BEATS = CL_WIDTH/MEM_DATA_WIDTH (power of two, >= 1); BEAT_CNT_W = max(1, $clog2(BEATS)); OCC_W = $clog2(LINE_FIFO_DEPTH+1).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
line_valid_i  in  1  line response valid
line_ready_o  out  1  line accepted when valid and ready
line_id_i  in  MEM_ID_WIDTH  transaction ID
line_data_i  in  CL_WIDTH  full line data
line_error_i  in  1  line response error
beat_valid_o  out  1  beat valid
beat_ready_i  in  1  cache accepts beat
beat_id_o  out  MEM_ID_WIDTH  ID of the current line
beat_data_o  out  MEM_DATA_WIDTH  current beat slice
beat_error_o  out  1  error flag, copied onto every beat
beat_last_o  out  1  final beat of the line
occupancy_o  out  OCC_W  lines held, including the one being sent
busy_o  out  1  occupancy_o != 0

Behaviour:
- Reset, asynchronous, while rst_i=1: FIFO emptied, beat counter=0, FSM=IDLE. Outputs: line_ready_o=1, beat_valid_o=0, beat_last_o=0, beat_error_o=0, beat_id_o=0, beat_data_o=0, occupancy_o=0, busy_o=0.
- Reset mid-line: the in-flight line and all queued lines are discarded. No partial beats are emitted after release.
- line_ready_o = (occupancy < LINE_FIFO_DEPTH). It is a function of state only, with no combinational path from beat_ready_i. When full, no push is accepted even if a pop happens in the same cycle.
- Push on line_valid_i & line_ready_o. Stores {id, error, data} at the write pointer. Pointers wrap modulo LINE_FIFO_DEPTH.
- FSM IDLE: if the FIFO is non-empty, go to SEND and set beat counter=0. Latency from push into an empty FIFO to first beat_valid_o is 1 cycle.
- FSM SEND:
  - beat_valid_o=1.
  - beat_data_o = head.data[cnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], least-significant slice first.
  - beat_id_o and beat_error_o come from head.
  - beat_last_o = (cnt == BEATS-1).
- On beat_valid_o & beat_ready_i: if not last, cnt++. If last, pop the head and set cnt=0. Then:
  - stay in SEND if another line remains after the pop (counting a simultaneous push), with no bubble between lines;
  - otherwise go to IDLE.
- Stability: while beat_valid_o=1 and beat_ready_i=0, all beat_* outputs hold.
- BEATS==1: beat_last_o=1 on every beat; cnt stays 0.
- Simultaneous push and pop: occupancy is unchanged. A push into a non-full FIFO during the final beat is legal and queues behind.
- Error lines still emit all BEATS beats (data as supplied), with beat_error_o=1 on each.
- occupancy_o is registered and updates the cycle after each push/pop.
- Assertions (simulation only):
  - line_* inputs stable while line_valid_i & !line_ready_o;
  - CL_WIDTH % MEM_DATA_WIDTH == 0;
  - no X on beat_ready_i out of reset.

Decomposition:
- Shared package hpdcache_mem_refill_pkg:
  - typedef line_entry_t {id, error, data};
  - function beats_of(cl_w, mem_w);
  - FSM enum refill_ser_state_e {IDLE, SEND}.
- Parameter defaults are taken from hpdcache_params_pkg constants.
- One sub-module: hpdcache_mem_refill_line_fifo, a generic depth-N valid/ready FIFO of line_entry_t with an occupancy output. The top holds the FSM, beat counter and slice mux.

Test Plan:
- Single line, id=3, data=512'h{8 words 0x..07,...,0x..00}, beat_ready_i=1 → 8 beats on consecutive cycles, first beat 1 cycle after accept. Beat k carries word k; beat_last_o only on beat 7; occupancy 1→0.
- Back-pressure: beat_ready_i toggles 1,0,0,1… → each beat is held stable while stalled. Exactly 8 handshakes; no duplicated or skipped slice.
- Fill: 3 lines pushed (ids 1,2,3) with beat_ready_i=0 → ids 1,2 accepted; line_ready_o=0 with occupancy=2; id 3 accepted the cycle after the first line's last beat pops. Output order is 1,2,3 with no bubble between lines.
- Error line id=5 with line_error_i=1 → 8 beats, all with beat_error_o=1 and id 5. The following clean line id=6 has beat_error_o=0.
- Reset asserted after beat 3 of line id=7 with a second line queued → outputs immediately take reset values. After release there are no beats and line_ready_o=1. A new line id=8 serializes from beat 0.
- BEATS==1 configuration (CL_WIDTH=64) with 4 back-to-back lines → one beat per line, beat_last_o=1 on all, throughput 1 line/cycle when beat_ready_i=1.
